// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Purpose  : Two-read / two-write register file with a per-register load
//            scoreboard. Write port A carries ALU results, write port B carries
//            load data returning from memory and releases the pending mark.
//            Optional same-cycle write-to-read bypass and hard-wired zero r0.
// Ports    : Clock, nReset                - clock (rising), async active-low reset
//            RAddr1/2 -> RData1/2, Busy1/2 - combinational read ports + stall flags
//            WeA, WAddrA, WDataA          - ALU write port (wins on address clash)
//            WeB, WAddrB, WDataB          - load-return write port, clears busy
//            Claim, ClaimAddr             - mark a register pending for a load
//            BusyVec                      - registered scoreboard, bit i = reg i
//            Err                          - registered one-cycle hazard pulse
// Revision : 1.0 - initial release
// ============================================================================
module regfile_sb #(
  parameter int N       = 16,
  parameter int REGS    = 8,
  parameter int AW      = 3,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic            Clock,
  input  logic            nReset,
  input  logic [AW-1:0]   RAddr1,
  input  logic [AW-1:0]   RAddr2,
  output logic [N-1:0]    RData1,
  output logic [N-1:0]    RData2,
  output logic            Busy1,
  output logic            Busy2,
  input  logic            WeA,
  input  logic [AW-1:0]   WAddrA,
  input  logic [N-1:0]    WDataA,
  input  logic            WeB,
  input  logic [AW-1:0]   WAddrB,
  input  logic [N-1:0]    WDataB,
  input  logic            Claim,
  input  logic [AW-1:0]   ClaimAddr,
  output logic [REGS-1:0] BusyVec,
  output logic            Err
);

  localparam logic c_bypass = (BYPASS != 0);
  localparam logic c_zero0  = (ZERO_R0 != 0);

  // An address names a real, writable register: in range and not the
  // hard-wired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (int'(a) < REGS) && !(c_zero0 && (a == '0));
  endfunction

  // --------------------------------------------------------------------------
  // Qualified write / claim strobes
  // --------------------------------------------------------------------------
  logic w_wa_ok;
  logic w_wb_ok;
  logic w_wb_commit;
  logic w_claim_ok;

  assign w_wa_ok     = WeA && addr_ok(WAddrA);
  assign w_wb_ok     = WeB && addr_ok(WAddrB);
  // Port A has priority; a load return to the same register is dropped.
  assign w_wb_commit = w_wb_ok && !(w_wa_ok && (WAddrA == WAddrB));
  assign w_claim_ok  = Claim && addr_ok(ClaimAddr);

  // --------------------------------------------------------------------------
  // Register storage and scoreboard bits, one slice per register
  // --------------------------------------------------------------------------
  logic [REGS*N-1:0] w_regs_flat;

  for (genvar gi = 0; gi < REGS; gi++) begin : g_reg
    if (c_zero0 && (gi == 0)) begin : g_zero
      assign w_regs_flat[gi*N +: N] = '0;
      assign BusyVec[gi]            = 1'b0;
    end else begin : g_live
      logic [N-1:0] r_data;
      logic         r_busy;
      logic         w_set;
      logic         w_clr;

      assign w_set = w_claim_ok && (ClaimAddr == AW'(gi));
      assign w_clr = WeB && (WAddrB == AW'(gi));

      always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
          r_data <= '0;
          r_busy <= 1'b0;
        end else begin
          if (w_wa_ok && (WAddrA == AW'(gi))) begin
            r_data <= WDataA;
          end else if (w_wb_commit && (WAddrB == AW'(gi))) begin
            r_data <= WDataB;
          end
          // A new claim outranks a same-cycle return: the new load is
          // still outstanding after this edge.
          if (w_set) begin
            r_busy <= 1'b1;
          end else if (w_clr) begin
            r_busy <= 1'b0;
          end
        end
      end

      assign w_regs_flat[gi*N +: N] = r_data;
      assign BusyVec[gi]            = r_busy;
    end
  end

  // --------------------------------------------------------------------------
  // Address lookups into storage and scoreboard
  // --------------------------------------------------------------------------
  logic [N-1:0] w_st1;
  logic [N-1:0] w_st2;
  logic         w_bv1;
  logic         w_bv2;
  logic         w_claim_busy;
  logic         w_wa_busy;

  always_comb begin
    w_st1        = '0;
    w_st2        = '0;
    w_bv1        = 1'b0;
    w_bv2        = 1'b0;
    w_claim_busy = 1'b0;
    w_wa_busy    = 1'b0;
    for (int i = 0; i < REGS; i++) begin
      if (RAddr1 == AW'(i)) begin
        w_st1 = w_regs_flat[i*N +: N];
        w_bv1 = BusyVec[i];
      end
      if (RAddr2 == AW'(i)) begin
        w_st2 = w_regs_flat[i*N +: N];
        w_bv2 = BusyVec[i];
      end
      if (ClaimAddr == AW'(i)) begin
        w_claim_busy = BusyVec[i];
      end
      if (WAddrA == AW'(i)) begin
        w_wa_busy = BusyVec[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read ports. Outputs are forced to zero while reset is held so that a
  // bypassed write cannot leak through during reset.
  // --------------------------------------------------------------------------
  logic w_fa1;
  logic w_fa2;
  logic w_fb1;
  logic w_fb2;
  logic w_rd1_ok;
  logic w_rd2_ok;

  assign w_rd1_ok = nReset && addr_ok(RAddr1);
  assign w_rd2_ok = nReset && addr_ok(RAddr2);

  assign w_fa1 = c_bypass && WeA && (WAddrA == RAddr1);
  assign w_fa2 = c_bypass && WeA && (WAddrA == RAddr2);
  assign w_fb1 = c_bypass && WeB && (WAddrB == RAddr1);
  assign w_fb2 = c_bypass && WeB && (WAddrB == RAddr2);

  assign RData1 = !w_rd1_ok ? '0 : (w_fa1 ? WDataA : (w_fb1 ? WDataB : w_st1));
  assign RData2 = !w_rd2_ok ? '0 : (w_fa2 ? WDataA : (w_fb2 ? WDataB : w_st2));

  // With bypass the returning load data is already on RData, so the stall
  // can drop in the return cycle itself.
  assign Busy1 = w_rd1_ok && w_bv1 && !w_fb1;
  assign Busy2 = w_rd2_ok && w_bv2 && !w_fb2;

  // --------------------------------------------------------------------------
  // Hazard detection
  // --------------------------------------------------------------------------
  logic w_err;
  logic r_err;

  assign w_err = (w_wa_ok && WeB && (WAddrB == WAddrA))
               || (w_claim_ok && w_claim_busy && !(WeB && (WAddrB == ClaimAddr)))
               || (w_wa_ok && w_wa_busy);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_err;
    end
  end

  assign Err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_sb
// Purpose  : Self-checking bench for regfile_sb (default parameters:
//            N=16, REGS=8, AW=3, ZERO_R0=1, BYPASS=1). A reference model
//            predicts every output; predictions are queued when stimulus is
//            applied and compared when the DUT output is sampled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

  logic        Clock;
  logic        nReset;
  logic [2:0]  RAddr1, RAddr2;
  logic [15:0] RData1, RData2;
  logic        Busy1, Busy2;
  logic        WeA, WeB, Claim;
  logic [2:0]  WAddrA, WAddrB, ClaimAddr;
  logic [15:0] WDataA, WDataB;
  logic [7:0]  BusyVec;
  logic        Err;

  regfile_sb dut (
    .Clock     (Clock),
    .nReset    (nReset),
    .RAddr1    (RAddr1),
    .RAddr2    (RAddr2),
    .RData1    (RData1),
    .RData2    (RData2),
    .Busy1     (Busy1),
    .Busy2     (Busy2),
    .WeA       (WeA),
    .WAddrA    (WAddrA),
    .WDataA    (WDataA),
    .WeB       (WeB),
    .WAddrB    (WAddrB),
    .WDataB    (WDataB),
    .Claim     (Claim),
    .ClaimAddr (ClaimAddr),
    .BusyVec   (BusyVec),
    .Err       (Err)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference model state
  logic [15:0] m_regs [8];
  logic [7:0]  m_busy;

  // Scoreboard
  string       tag_q [$];
  logic [31:0] val_q [$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    val_q.push_back(v);
  endtask

  task automatic sb_pop_check(input logic [31:0] obs);
    if (val_q.size() == 0) begin
      check_val("sb_empty", 32'(val_q.size()), 32'd1);
    end else begin
      check_val(tag_q.pop_front(), obs, val_q.pop_front());
    end
  endtask

  function automatic logic v_ok(input logic [2:0] a);
    return a != 3'd0;
  endfunction

  function automatic logic [15:0] exp_rd(input logic [2:0] a);
    if (!nReset || !v_ok(a)) return 16'h0;
    if (WeA && WAddrA == a) return WDataA;
    if (WeB && WAddrB == a) return WDataB;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [2:0] a);
    return nReset && v_ok(a) && m_busy[a] && !(WeB && WAddrB == a);
  endfunction

  task automatic set_idle();
    WeA = 0; WAddrA = 0; WDataA = 0;
    WeB = 0; WAddrB = 0; WDataB = 0;
    Claim = 0; ClaimAddr = 0;
    RAddr1 = 0; RAddr2 = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
    m_busy = 8'h0;
  endtask

  // All outputs must read zero while reset is asserted.
  task automatic chk_reset();
    sb_push("rst_rdata1", 0); sb_push("rst_rdata2", 0);
    sb_push("rst_busy1", 0);  sb_push("rst_busy2", 0);
    sb_push("rst_busyvec", 0); sb_push("rst_err", 0);
    #1;
    sb_pop_check(RData1); sb_pop_check(RData2);
    sb_pop_check(Busy1);  sb_pop_check(Busy2);
    sb_pop_check(BusyVec); sb_pop_check(Err);
  endtask

  // One clock cycle of stimulus with full prediction and checking.
  task automatic cyc(input logic wea, input logic [2:0] aa, input logic [15:0] da,
                     input logic web, input logic [2:0] ab, input logic [15:0] db,
                     input logic cl, input logic [2:0] ca,
                     input logic [2:0] r1, input logic [2:0] r2);
    logic [15:0] nregs [8];
    logic [7:0]  nbusy;
    logic        nerr;
    @(negedge Clock);
    WeA = wea; WAddrA = aa; WDataA = da;
    WeB = web; WAddrB = ab; WDataB = db;
    Claim = cl; ClaimAddr = ca;
    RAddr1 = r1; RAddr2 = r2;

    sb_push("rdata1", exp_rd(r1));
    sb_push("rdata2", exp_rd(r2));
    sb_push("busy1", exp_busy(r1));
    sb_push("busy2", exp_busy(r2));

    nregs = m_regs;
    nbusy = m_busy;
    if (wea && v_ok(aa)) nregs[aa] = da;
    if (web && v_ok(ab) && !(wea && v_ok(aa) && aa == ab)) nregs[ab] = db;
    for (int i = 1; i < 8; i++) begin
      if (cl && ca == 3'(i))      nbusy[i] = 1'b1;
      else if (web && ab == 3'(i)) nbusy[i] = 1'b0;
    end
    nerr = (wea && web && aa == ab && v_ok(aa))
        || (cl && v_ok(ca) && m_busy[ca] && !(web && ab == ca))
        || (wea && v_ok(aa) && m_busy[aa]);
    sb_push("busyvec", nbusy);
    sb_push("err", nerr);

    #1;
    sb_pop_check(RData1); sb_pop_check(RData2);
    sb_pop_check(Busy1);  sb_pop_check(Busy2);
    @(posedge Clock);
    #1;
    sb_pop_check(BusyVec); sb_pop_check(Err);
    m_regs = nregs;
    m_busy = nbusy;
  endtask

  initial begin
    model_reset();
    // Reset held, with an active write aimed at the read address
    nReset = 1'b0;
    set_idle();
    WeA = 1; WAddrA = 3; WDataA = 16'h5555; RAddr1 = 3; RAddr2 = 3;
    #2;
    chk_reset();
    set_idle();
    #10 nReset = 1'b1;

    // Write via A, read back next cycle
    cyc(1, 3, 16'h1234, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0,        0, 0, 0, 0, 0, 3, 0);
    check_val("t1_r3", RData1, 16'h1234);

    // Same-cycle bypass from port A
    cyc(1, 5, 16'hBEEF, 0, 0, 0, 0, 0, 0, 5);

    // Claim, stall, load return releases stall in its own cycle
    cyc(0, 0, 0, 0, 0, 0,        1, 2, 0, 0);
    cyc(0, 0, 0, 0, 0, 0,        0, 0, 2, 0);
    cyc(0, 0, 0, 1, 2, 16'h00AA, 0, 0, 2, 0);
    cyc(0, 0, 0, 0, 0, 0,        0, 0, 2, 2);

    // Zero register ignores writes and claims
    cyc(1, 0, 16'hFFFF, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0,        0, 0, 0, 0, 0, 0, 0);

    // Dual write to one register: A wins, single-cycle Err
    cyc(1, 4, 16'h1111, 1, 4, 16'h2222, 0, 0, 4, 0);
    cyc(0, 0, 0,        0, 0, 0,        0, 0, 4, 0);

    // Claim + same-address return keeps busy; WeA to busy and re-claim flag Err
    cyc(0, 0, 0,        0, 0, 0,        1, 7, 7, 0);
    cyc(0, 0, 0,        1, 7, 16'h0777, 1, 7, 7, 7);
    cyc(1, 7, 16'h7070, 0, 0, 0,        0, 0, 7, 0);
    cyc(0, 0, 0,        0, 0, 0,        1, 7, 7, 0);
    cyc(0, 0, 0,        1, 7, 16'h0007, 0, 0, 7, 0);

    // Claim, then reset mid-cycle: everything clears before the next edge
    cyc(0, 0, 0, 0, 0, 0, 1, 6, 6, 0);
    @(negedge Clock);
    WeA = 1; WAddrA = 6; WDataA = 16'hABCD; RAddr1 = 6; RAddr2 = 5;
    #1 nReset = 1'b0;
    chk_reset();
    model_reset();
    set_idle();
    #1 nReset = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 6, 5);

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      cyc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
          1'($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), 16'($urandom),
          1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
